lab3_cache_refill_ctrl: RTL and testbench

Miss-handling sequencer for the two-stage (M0/M1) write-back, direct-mapped cache. When M1 reports a tag miss, this block stalls the cache pipeline, writes back the dirty victim line word by word, refills the requested line from memory, and updates the tag array. It then pulses `done` so M1 replays the access. It drives only control signals: datapath read/write enables, word indices and address select.

---
 rtl/lab3_cache_refill_ctrl.sv | 122 ++++++++++++
 tb/tb_lab3_cache_refill_ctrl.sv | 285 ++++++++++++++++++++++++++++
 2 files changed

// File: rtl/lab3_cache_refill_ctrl.sv
// Miss-handling sequencer for a two-stage write-back, direct-mapped cache.
// Accepts a tag miss from M1, stalls the pipeline, evicts a dirty victim word by word,
// refills the requested line, writes the tag array, then pulses done so M1 replays.
module lab3_cache_refill_ctrl #(
    parameter int unsigned p_line_words = 4,
    localparam int unsigned W = $clog2(p_line_words)
) (
    input  logic         clk,
    input  logic         reset,
    input  logic         miss_val,
    input  logic         miss_dirty,
    output logic         miss_rdy,
    output logic         stall,
    output logic         mem_addr_sel,
    output logic         memreq_val,
    input  logic         memreq_rdy,
    output logic         memreq_type,
    output logic [W-1:0] memreq_word_idx,
    input  logic         memresp_val,
    output logic         memresp_rdy,
    output logic         refill_we,
    output logic [W-1:0] refill_word_idx,
    output logic         tarray_we,
    output logic         done
);

    typedef enum logic [1:0] {StIdle, StEvict, StRefill, StUpdate} state_e;

    localparam logic [W:0] LineWords = (W + 1)'(p_line_words);
    localparam logic [W:0] LastResp  = LineWords - (W + 1)'(1);

    state_e     state_q, state_d;
    logic [W:0] req_cnt_q, req_cnt_d;
    logic [W:0] resp_cnt_q, resp_cnt_d;

    // State and counter registers; reset aborts any miss in flight.
    always_ff @(posedge clk) begin
        if (reset) begin
            state_q    <= StIdle;
            req_cnt_q  <= '0;
            resp_cnt_q <= '0;
        end else begin
            state_q    <= state_d;
            req_cnt_q  <= req_cnt_d;
            resp_cnt_q <= resp_cnt_d;
        end
    end

    // Next-state and control outputs decoded from the current state.
    always_comb begin
        state_d         = state_q;
        miss_rdy        = 1'b0;
        stall           = 1'b0;
        mem_addr_sel    = 1'b0;
        memreq_val      = 1'b0;
        memreq_type     = 1'b0;
        memreq_word_idx = '0;
        memresp_rdy     = 1'b0;
        refill_we       = 1'b0;
        refill_word_idx = '0;
        tarray_we       = 1'b0;
        done            = 1'b0;
        unique case (state_q)
            StIdle: begin
                miss_rdy = 1'b1;
                // Freeze M0/M1 in the same cycle the miss is accepted.
                stall    = miss_val;
                if (miss_val) begin
                    state_d = miss_dirty ? StEvict : StRefill;
                end
            end
            StEvict: begin
                stall           = 1'b1;
                memreq_type     = 1'b1;
                memreq_val      = (req_cnt_q < LineWords);
                memreq_word_idx = req_cnt_q[W-1:0];
                memresp_rdy     = 1'b1;
                if (memresp_val && (resp_cnt_q == LastResp)) begin
                    state_d = StRefill;
                end
            end
            StRefill: begin
                stall           = 1'b1;
                mem_addr_sel    = 1'b1;
                memreq_val      = (req_cnt_q < LineWords);
                memreq_word_idx = req_cnt_q[W-1:0];
                memresp_rdy     = 1'b1;
                // Responses arrive in order, so the response count is the word index.
                refill_we       = memresp_val;
                refill_word_idx = resp_cnt_q[W-1:0];
                if (memresp_val && (resp_cnt_q == LastResp)) begin
                    state_d = StUpdate;
                end
            end
            StUpdate: begin
                stall     = 1'b1;
                tarray_we = 1'b1;
                done      = 1'b1;
                state_d   = StIdle;
            end
            default: state_d = StIdle;
        endcase
    end

    // Request/response counters; cleared whenever the state changes.
    always_comb begin
        req_cnt_d  = req_cnt_q;
        resp_cnt_d = resp_cnt_q;
        if (state_d != state_q) begin
            req_cnt_d  = '0;
            resp_cnt_d = '0;
        end else begin
            if (memreq_val && memreq_rdy) begin
                req_cnt_d = req_cnt_q + (W + 1)'(1);
            end
            if (memresp_val && memresp_rdy) begin
                resp_cnt_d = resp_cnt_q + (W + 1)'(1);
            end
        end
    end

endmodule

// File: tb/tb_lab3_cache_refill_ctrl.sv
// Self-checking bench for lab3_cache_refill_ctrl: a queue-based memory with random latency
// and ready patterns, checked against a transaction-level model of one miss.
module tb_lab3_cache_refill_ctrl;

    localparam int N = 4;
    localparam int W = 2;

    logic         clk;
    logic         reset;
    logic         miss_val;
    logic         miss_dirty;
    logic         miss_rdy;
    logic         stall;
    logic         mem_addr_sel;
    logic         memreq_val;
    logic         memreq_rdy;
    logic         memreq_type;
    logic [W-1:0] memreq_word_idx;
    logic         memresp_val;
    logic         memresp_rdy;
    logic         refill_we;
    logic [W-1:0] refill_word_idx;
    logic         tarray_we;
    logic         done;

    int vectors;
    int errors;

    lab3_cache_refill_ctrl #(.p_line_words(N)) dut (
        .clk            (clk),
        .reset          (reset),
        .miss_val       (miss_val),
        .miss_dirty     (miss_dirty),
        .miss_rdy       (miss_rdy),
        .stall          (stall),
        .mem_addr_sel   (mem_addr_sel),
        .memreq_val     (memreq_val),
        .memreq_rdy     (memreq_rdy),
        .memreq_type    (memreq_type),
        .memreq_word_idx(memreq_word_idx),
        .memresp_val    (memresp_val),
        .memresp_rdy    (memresp_rdy),
        .refill_we      (refill_we),
        .refill_word_idx(refill_word_idx),
        .tarray_we      (tarray_we),
        .done           (done)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    // Idle output bundle: {miss_rdy, stall, sel, req_val, type, resp_rdy, refill_we, tarray_we, done}
    function automatic logic [8:0] idle_bundle();
        return {miss_rdy, stall, mem_addr_sel, memreq_val, memreq_type, memresp_rdy,
                refill_we, tarray_we, done};
    endfunction

    task automatic test_reset();
        reset = 1'b1; miss_val = 1'b0; miss_dirty = 1'b0;
        memreq_rdy = 1'b0; memresp_val = 1'b0;
        @(posedge clk); @(posedge clk); #1;
        vectors++;
        if (idle_bundle() !== 9'b100000000) begin
            errors++;
            $display("FAIL reset_outputs: got %b expected %b", idle_bundle(), 9'b100000000);
        end
        miss_val = 1'b1; #1;
        vectors++;
        if (stall !== 1'b1 || miss_rdy !== 1'b1) begin
            errors++;
            $display("FAIL reset_stall_follows_miss: got stall=%b miss_rdy=%b expected 1 1",
                     stall, miss_rdy);
        end
        miss_val = 1'b0; reset = 1'b0;
        @(posedge clk); #1;
    endtask

    // One complete miss against the memory model. exp_done < 0 skips the exact-cycle check.
    task automatic run_miss(input bit dirty, input int lat_max, input int rdy_mode,
                            input int exp_done, input string name);
        int q_due[$];
        int cyc, iss_w, iss_r, rcount, need;
        bit in_evict, done_exp, exp_val, fin, prev_hold;
        logic [W-1:0] prev_idx, exp_idx, exp_fill;
        cyc = 0; iss_w = 0; iss_r = 0; rcount = 0; fin = 0; prev_hold = 0; prev_idx = '0;
        need = dirty ? 2 * N : N;
        // Acceptance cycle.
        miss_val = 1'b1; miss_dirty = dirty; memreq_rdy = 1'b0; memresp_val = 1'b0; #1;
        vectors++;
        if ({miss_rdy, stall, memreq_val} !== 3'b110) begin
            errors++;
            $display("FAIL %s accept: got rdy/stall/req=%b expected 110", name,
                     {miss_rdy, stall, memreq_val});
        end
        @(posedge clk); #1;
        cyc = 1;
        while (!fin && cyc < 200) begin
            miss_val   = 1'($urandom);
            miss_dirty = 1'($urandom);
            case (rdy_mode)
                0:       memreq_rdy = 1'b1;
                1:       memreq_rdy = 1'($urandom);
                default: memreq_rdy = (cyc % 3 == 1);
            endcase
            memresp_val = (q_due.size() > 0) && (q_due[0] <= cyc);
            #1;
            in_evict = dirty && (rcount < N);
            done_exp = (rcount == need);
            vectors++;
            if ({stall, miss_rdy, done, tarray_we} !== {1'b1, 1'b0, done_exp, done_exp}) begin
                errors++;
                $display("FAIL %s busy_ctrl cyc %0d: got stall/rdy/done/twe=%b expected %b",
                         name, cyc, {stall, miss_rdy, done, tarray_we},
                         {1'b1, 1'b0, done_exp, done_exp});
            end
            if (done_exp) begin
                vectors++;
                if ({memreq_val, memresp_rdy, refill_we} !== 3'b000) begin
                    errors++;
                    $display("FAIL %s update_quiet: got req/resp_rdy/we=%b expected 000", name,
                             {memreq_val, memresp_rdy, refill_we});
                end
                if (exp_done >= 0) begin
                    vectors++;
                    if (cyc != exp_done) begin
                        errors++;
                        $display("FAIL %s done_cycle: got %0d expected %0d", name, cyc, exp_done);
                    end
                end
                fin = 1;
            end else begin
                exp_val = in_evict ? (iss_w < N) : (iss_r < N);
                exp_idx = in_evict ? W'(iss_w) : W'(iss_r);
                vectors++;
                if ({memreq_val, memresp_rdy, mem_addr_sel, refill_we} !==
                    {exp_val, 1'b1, !in_evict, memresp_val && !in_evict}) begin
                    errors++;
                    $display("FAIL %s phase cyc %0d: got val/resp_rdy/sel/we=%b expected %b",
                             name, cyc, {memreq_val, memresp_rdy, mem_addr_sel, refill_we},
                             {exp_val, 1'b1, !in_evict, memresp_val && !in_evict});
                end
                if (memreq_val && exp_val) begin
                    vectors++;
                    if ({memreq_type, memreq_word_idx} !== {in_evict, exp_idx}) begin
                        errors++;
                        $display("FAIL %s req cyc %0d: got type/idx=%b/%0d expected %b/%0d",
                                 name, cyc, memreq_type, memreq_word_idx, in_evict, exp_idx);
                    end
                end
                if (prev_hold) begin
                    vectors++;
                    if (memreq_val !== 1'b1 || memreq_word_idx !== prev_idx) begin
                        errors++;
                        $display("FAIL %s req_hold cyc %0d: got val/idx=%b/%0d expected 1/%0d",
                                 name, cyc, memreq_val, memreq_word_idx, prev_idx);
                    end
                end
                if (refill_we && !in_evict) begin
                    exp_fill = W'(rcount - (dirty ? N : 0));
                    vectors++;
                    if (refill_word_idx !== exp_fill) begin
                        errors++;
                        $display("FAIL %s refill_idx cyc %0d: got %0d expected %0d", name, cyc,
                                 refill_word_idx, exp_fill);
                    end
                end
                if (exp_val && memreq_val && memreq_rdy) begin
                    q_due.push_back(cyc + int'($urandom_range(lat_max, 1)));
                    if (in_evict) iss_w++;
                    else iss_r++;
                end
                if (memresp_val) begin
                    void'(q_due.pop_front());
                    rcount++;
                end
                prev_hold = memreq_val && !memreq_rdy;
                prev_idx  = memreq_word_idx;
            end
            @(posedge clk); #1;
            cyc++;
        end
        if (!fin) begin
            vectors++;
            errors++;
            $display("FAIL %s timeout: got no done after %0d cycles expected done", name, cyc);
        end
        miss_val = 1'b0; memreq_rdy = 1'b0; memresp_val = 1'b0; #1;
        vectors++;
        if (idle_bundle() !== 9'b100000000) begin
            errors++;
            $display("FAIL %s back_to_idle: got %b expected %b", name, idle_bundle(),
                     9'b100000000);
        end
        @(posedge clk); #1;
    endtask

    task automatic test_clean_timing();
        run_miss(1'b0, 1, 0, N + 2, "clean_lat1");
    endtask

    task automatic test_dirty_timing();
        run_miss(1'b1, 1, 0, 2 * N + 3, "dirty_lat1");
    endtask

    task automatic test_rdy_toggle();
        run_miss(1'b0, 1, 2, -1, "rdy_toggle");
    endtask

    task automatic test_resp_gaps();
        run_miss(1'b0, 3, 0, -1, "resp_gaps");
        run_miss(1'b1, 4, 1, -1, "resp_gaps_dirty");
    endtask

    task automatic test_reset_mid_refill();
        miss_val = 1'b1; miss_dirty = 1'b0; memreq_rdy = 1'b1; memresp_val = 1'b0;
        @(posedge clk); #1;
        miss_val = 1'b0;
        for (int c = 1; c <= 3; c++) begin
            memresp_val = (c >= 2);
            #1;
            vectors++;
            if ({refill_we, memreq_val} !== {memresp_val, 1'b1}) begin
                errors++;
                $display("FAIL rst_mid prefix cyc %0d: got we/req=%b expected %b", c,
                         {refill_we, memreq_val}, {memresp_val, 1'b1});
            end
            @(posedge clk); #1;
        end
        reset = 1'b1; memreq_rdy = 1'b0; memresp_val = 1'b0; #1;
        vectors++;
        if ({tarray_we, done} !== 2'b00) begin
            errors++;
            $display("FAIL rst_mid no_update: got twe/done=%b expected 00", {tarray_we, done});
        end
        @(posedge clk); #1;
        reset = 1'b0; #1;
        vectors++;
        if (idle_bundle() !== 9'b100000000) begin
            errors++;
            $display("FAIL rst_mid idle: got %b expected %b", idle_bundle(), 9'b100000000);
        end
        @(posedge clk); #1;
        run_miss(1'b0, 1, 0, N + 2, "after_reset");
    endtask

    task automatic test_idle_ignore();
        miss_val = 1'b0; memreq_rdy = 1'b1;
        for (int c = 0; c < 3; c++) begin
            memresp_val = 1'b1; #1;
            vectors++;
            if (idle_bundle() !== 9'b100000000) begin
                errors++;
                $display("FAIL idle_resp cyc %0d: got %b expected %b", c, idle_bundle(),
                         9'b100000000);
            end
            @(posedge clk); #1;
        end
        memresp_val = 1'b0;
        // Exact timing afterwards shows the stray responses moved no counter.
        run_miss(1'b1, 1, 0, 2 * N + 3, "after_idle_resp");
    endtask

    task automatic test_random();
        for (int k = 0; k < 25; k++) begin
            run_miss(1'($urandom), int'($urandom_range(4, 1)), int'($urandom_range(2, 0)), -1,
                     "random");
        end
    endtask

    initial begin
        vectors = 0;
        errors  = 0;
        test_reset();
        test_clean_timing();
        test_dirty_timing();
        test_rdy_toggle();
        test_resp_gaps();
        test_reset_mid_refill();
        test_idle_ignore();
        test_random();
        $display("== %0d vectors applied, %0d miscompares ==", vectors, errors);
        $finish;
    end

endmodule
